// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-type encodings and the hardwired zero register.
// The encodings follow the RISC-V funct3 values for loads.
package cpu_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_ext.sv
// Load extraction: selects the addressed byte/halfword of a raw memory word,
// sign- or zero-extends it, and flags misaligned word/halfword accesses.
// Purely combinational; only instantiated when WB_LOAD_EXT_EN is defined.
module load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadtype,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [15:0] half;
  logic [7:0]  bsel;

  // Pick the lane, then extend according to the load type.
  always_comb begin
    data       = raw;
    misaligned = 1'b0;
    half       = offset[1] ? raw[31:16] : raw[15:0];
    case (offset)
      2'd0:    bsel = raw[7:0];
      2'd1:    bsel = raw[15:8];
      2'd2:    bsel = raw[23:16];
      default: bsel = raw[31:24];
    endcase
    case (loadtype)
      LT_LW: begin
        data       = raw;
        misaligned = (offset != 2'd0);
      end
      LT_LH: begin
        data       = {{16{half[15]}}, half};
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = {16'h0000, half};
        misaligned = offset[0];
      end
      LT_LB:   data = {{24{bsel[7]}}, bsel};
      LT_LBU:  data = {24'h000000, bsel};
      // Unknown encodings fall back to a whole-word load with no alignment check.
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction in front of it, a write
// enable qualifier, a registered misaligned-load flag and a retired-write counter.
// Build option: define WB_LOAD_EXT_EN to get sub-word loads and misalignment
// detection; otherwise loads pass the raw memory word and misalign_o stays 0.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             regwrite_i,
  input  logic             memtoreg_i,
  input  logic [4:0]       writereg_i,
  input  logic [31:0]      aluout_i,
  input  logic [31:0]      readdata_i,
  input  logic [2:0]       loadtype_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             we3_o,
  output logic [4:0]       wa3_o,
  output logic [31:0]      wd3_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] wcount_o
);

  logic [31:0] load_data;
  logic        load_mis;

`ifdef WB_LOAD_EXT_EN
  load_ext u_load_ext (
    .raw        (readdata_i),
    .offset     (aluout_i[1:0]),
    .loadtype   (loadtype_i),
    .data       (load_data),
    .misaligned (load_mis)
  );
`else
  logic unused_loadtype;
  assign unused_loadtype = ^loadtype_i;
  assign load_data       = readdata_i;
  assign load_mis        = 1'b0;
`endif

  logic [31:0] result;
  logic        mis_next;
  logic        we_next;
  logic        capture;

  // Next-state values for the pipeline register; a flush kills both flags.
  always_comb begin
    result   = memtoreg_i ? load_data : aluout_i;
    mis_next = valid_i & memtoreg_i & load_mis & ~flush_i;
    we_next  = valid_i & regwrite_i & (writereg_i != REG_ZERO)
             & ~(valid_i & memtoreg_i & load_mis) & ~flush_i;
    // Flush overrides stall so a killed instruction never lingers as a write.
    capture  = flush_i | ~stall_i;
  end

  // Pipeline register and committed-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_o      <= 1'b0;
      wa3_o      <= 5'd0;
      wd3_o      <= 32'd0;
      misalign_o <= 1'b0;
      wcount_o   <= '0;
    end else if (capture) begin
      we3_o      <= we_next;
      wa3_o      <= writereg_i;
      wd3_o      <= result;
      misalign_o <= mis_next;
      if (we_next) begin
        wcount_o <= wcount_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-write counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 valid_i  in  1  MEM stage holds a live instruction.
REQ-006 regwrite_i  in  1  instruction writes a GPR.
REQ-007 memtoreg_i  in  1  result is load data (1) or ALU result (0).
REQ-008 writereg_i  in  5  destination register number.
REQ-009 aluout_i  in  32  ALU result; bits [1:0] are also the load byte offset.
REQ-010 readdata_i  in  32  raw word from data memory.
REQ-011 loadtype_i  in  3  LW/LH/LHU/LB/LBU encoding from the shared package.
REQ-012 stall_i  in  1  hold the WB register.
REQ-013 flush_i  in  1  kill the instruction being captured.
REQ-014 we3_o  out  1  regfile write enable.
REQ-015 wa3_o  out  5  regfile write address.
REQ-016 wd3_o  out  32  regfile write data.
REQ-017 misalign_o  out  1  registered misaligned-load flag.
REQ-018 wcount_o  out  CNT_W  count of committed GPR writes.

Function
REQ-019 The block SHALL be one pipeline register: inputs are captured at a rising clk edge and appear on we3_o/wa3_o/wd3_o in the following cycle (latency 1); the regfile commits at the edge after that.
REQ-020 Load extraction and extension SHALL be computed before the register so that all outputs are driven directly by flops.
REQ-021 LW: whole word; LH/LHU: halfword at offset {aluout_i[1],0}, sign- or zero-extended; LB/LBU: byte at aluout_i[1:0], sign- or zero-extended.
REQ-022 memtoreg_i=0 SHALL select aluout_i unchanged, regardless of loadtype_i.
REQ-023 A misaligned load (LW with aluout_i[1:0]!=0, LH/LHU with aluout_i[0]=1) SHALL set misalign_o=1 and capture we3_o=0 for that instruction.
REQ-024 captured we3 SHALL equal valid_i & regwrite_i & (writereg_i!=0) & !misaligned & !flush_i.
REQ-025 stall_i=1 SHALL hold every output register and wcount_o unchanged.
REQ-026 flush_i SHALL take priority over stall_i: when both are 1, capture we3_o=0 and misalign_o=0; wa3_o/wd3_o are don't-care.
REQ-027 wcount_o SHALL increment by 1 at each edge where a we3=1 is captured, wrapping from all-ones to 0.
REQ-028 Back-to-back valid instructions with no stall SHALL be accepted every cycle with no bubble.

Reset
REQ-029 While rst_n=0: we3_o=0, wa3_o=0, wd3_o=0, misalign_o=0, wcount_o=0, asserted asynchronously.
REQ-030 Reset mid-operation SHALL discard the in-flight instruction; no write SHALL occur in the first cycle after release.

Configuration
REQ-031 Macro WB_LOAD_EXT_EN: when defined, sub-word loads and misalignment detection per REQ-021/REQ-023 are built.
REQ-032 Without WB_LOAD_EXT_EN, every load SHALL write readdata_i unchanged, misalign_o SHALL be tied to 0, and the extraction logic SHALL be absent.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the loadtype encodings (LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU) and REG_ZERO=5'd0.
REQ-034 One sub-module, load_ext (combinational: raw word, offset, loadtype -> extended data, misaligned), SHALL be instantiated only under WB_LOAD_EXT_EN.

Verification
REQ-035 ALU write: valid, regwrite, memtoreg=0, writereg=5, aluout=0x12345678 -> next cycle we3_o=1, wa3_o=5, wd3_o=0x12345678, wcount_o=1.
REQ-036 LB sign: readdata=0x00800000, aluout[1:0]=2, LB -> wd3_o=0xFFFFFF80; same with LBU -> 0x00000080.
REQ-037 Misaligned LH at aluout=0x1001 -> we3_o=0, misalign_o=1, wcount_o unchanged.
REQ-038 writereg=0 with regwrite=1 -> we3_o=0; stall_i=1 for 3 cycles -> outputs and wcount_o frozen; stall+flush together -> we3_o=0.
REQ-039 Preload wcount_o to all-ones via writes, one more write -> wcount_o=0; assert rst_n=0 mid-stream -> all outputs 0 immediately.
